// File: rtl/run_dump_ctrl_pkg.sv
// Shared definitions for the run-control / memory-dump sequencer.
package run_dump_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    DUMP = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] HC_NONE    = 2'b00;
  localparam logic [1:0] HC_TIMEOUT = 2'b01;
  localparam logic [1:0] HC_STALL   = 2'b10;
  localparam logic [1:0] HC_STORE   = 2'b11;

  // BEAT_BYTES for a given beat width.
  function automatic int unsigned beat_bytes(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/run_dump_ctrl_mem_dump_seq.sv
// Dump sequencer: walks the dmem window and feeds a one-entry valid/ready output register.
module mem_dump_seq
  import run_dump_ctrl_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 32,
  parameter int unsigned DUMP_BASE = 8192,
  parameter int unsigned DUMP_LAST = 8291
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [ADDR_W-1:0] dump_addr,
  input  logic [DATA_W-1:0] dump_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              dump_complete
);

  localparam int unsigned       BEAT_BYTES = beat_bytes(DATA_W);
  localparam int unsigned       NUM_BEATS  = (DUMP_LAST - DUMP_BASE) / BEAT_BYTES + 1;
  localparam logic [ADDR_W-1:0] BASE_A     = ADDR_W'(DUMP_BASE);
  localparam logic [ADDR_W-1:0] LAST_A     = ADDR_W'(DUMP_BASE + (NUM_BEATS - 1) * BEAT_BYTES);
  localparam logic [ADDR_W-1:0] STEP_A     = ADDR_W'(BEAT_BYTES);

  logic [ADDR_W-1:0] ptr;
  // Set once the last beat is loaded, so the pointer never has to be compared past the window.
  logic              issued_all;
  logic              load;
  logic              accept;

  assign load          = en && !issued_all && (!out_valid || out_ready);
  assign accept        = out_valid && out_ready;
  assign dump_complete = accept && out_last;
  assign dump_addr     = ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr        <= BASE_A;
      issued_all <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_addr   <= '0;
      out_last   <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= dump_rdata;
      out_addr  <= ptr;
      out_last  <= (ptr == LAST_A);
      ptr       <= ptr + STEP_A;
      if (ptr == LAST_A) issued_all <= 1'b1;
    end else if (accept) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/run_dump_ctrl.sv
// Run control: cycle counter, halt detection (store / PC stall / timeout) and RUN->DUMP->DONE FSM.
// Output beats: out_data/out_addr/out_last are valid while out_valid; a beat transfers on an edge
// with out_valid && out_ready, and the beat fields stay stable while out_valid && !out_ready.
module run_dump_ctrl
  import run_dump_ctrl_pkg::*;
#(
  parameter int          ADDR_W      = 32,
  parameter int          DATA_W      = 32,
  parameter int          CNT_W       = 32,
  parameter int          MAX_CYCLES  = 50000,
  parameter int          STALL_LIMIT = 16,
  parameter int unsigned HALT_ADDR   = 32'h0000_FFFC,
  parameter int unsigned DUMP_BASE   = 8192,
  parameter int unsigned DUMP_LAST   = 8291
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  output logic              core_hold,
  output logic              dump_req,
  output logic [ADDR_W-1:0] dump_addr,
  input  logic [DATA_W-1:0] dump_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              done,
  output logic [1:0]        halt_cause,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [1:0]        dbg_state
);

  localparam logic [ADDR_W-1:0] HALT_A = ADDR_W'(HALT_ADDR);

  state_t            state, state_nx;
  logic [1:0]        cause_q, cause_nx;
  logic [CNT_W-1:0]  cnt_q, cnt_inc;
  logic [CNT_W-1:0]  stall_cnt, stall_inc;
  logic [ADDR_W-1:0] prev_pc;
  logic              pc_same;
  logic              hit_store, hit_stall, hit_timeout;
  logic              dump_complete;

  always_comb begin
    cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    pc_same     = (pc == prev_pc);
    stall_inc   = '0;
    if (pc_same) stall_inc = (stall_cnt == '1) ? stall_cnt : stall_cnt + 1'b1;
    hit_store   = mem_write && (mem_addr == HALT_A);
    hit_stall   = (STALL_LIMIT != 0) && pc_same && (stall_inc == CNT_W'(STALL_LIMIT));
    hit_timeout = (cnt_inc == CNT_W'(MAX_CYCLES));
  end

  always_comb begin
    state_nx = state;
    cause_nx = cause_q;
    case (state)
      RUN: begin
        if (hit_store) begin
          state_nx = DUMP;
          cause_nx = HC_STORE;
        end else if (hit_stall) begin
          state_nx = DUMP;
          cause_nx = HC_STALL;
        end else if (hit_timeout) begin
          state_nx = DUMP;
          cause_nx = HC_TIMEOUT;
        end
      end
      DUMP:    if (dump_complete) state_nx = DONE;
      DONE:    state_nx = DONE;
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      cause_q   <= HC_NONE;
      cnt_q     <= '0;
      stall_cnt <= '0;
      prev_pc   <= '0;
    end else begin
      state   <= state_nx;
      cause_q <= cause_nx;
      // Counters and PC history freeze once the core is held.
      if (state == RUN) begin
        cnt_q     <= cnt_inc;
        stall_cnt <= stall_inc;
        prev_pc   <= pc;
      end
    end
  end

  assign core_hold   = (state != RUN);
  assign dump_req    = (state == DUMP);
  assign done        = (state == DONE);
  assign halt_cause  = cause_q;
  assign cycle_count = cnt_q;
  assign dbg_state   = state;

  mem_dump_seq #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .DUMP_BASE(DUMP_BASE),
    .DUMP_LAST(DUMP_LAST)
  ) u_seq (
    .clk          (clk),
    .rst          (rst),
    .en           (state == DUMP),
    .dump_addr    (dump_addr),
    .dump_rdata   (dump_rdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_addr     (out_addr),
    .out_last     (out_last),
    .dump_complete(dump_complete)
  );

endmodule
